systolic_arbiter: RTL and testbench

//  Shares one systolic matrix-multiply core between NREQ requesters. Arbitrates

---
 rtl/systolic_arbiter.sv | 150 +++++++++++++++
 tb/tb_systolic_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_arbiter.sv
// Round-robin front end for a shared systolic matrix-multiply core: holds the
// winning operands until the core accepts them and steers results to their owner.
module systolic_arbiter #(
   parameter int NREQ      = 4,
   parameter int ROWS      = 2,
   parameter int COLS      = 2,
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 9,
   parameter int MAX_OUT   = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREQ-1:0]                 req_valid,
   output logic [NREQ-1:0]                 req_ready,
   input  logic [NREQ*ROWS*ROWS*WIDTH-1:0] req_a,
   input  logic [NREQ*ROWS*COLS*WIDTH-1:0] req_b,
   output logic [ROWS*ROWS*WIDTH-1:0]      core_a,
   output logic [ROWS*COLS*WIDTH-1:0]      core_b,
   output logic                            core_in_valid,
   input  logic                            core_in_ready,
   input  logic [ROWS*COLS*ACC_WIDTH-1:0]  core_c,
   input  logic                            core_out_valid,
   output logic [ROWS*COLS*ACC_WIDTH-1:0]  rsp_c,
   output logic [NREQ-1:0]                 rsp_valid,
   output logic                            busy,
   output logic                            err_orphan
);

   localparam int AW  = ROWS*ROWS*WIDTH;
   localparam int BW  = ROWS*COLS*WIDTH;
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW  = $clog2(MAX_OUT) + 1;
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_OUT);
   localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   rr_ptr, hold_id, grant;
   logic             any_valid, grant_ok, handshake, push, pop;
   logic [IDW:0]     sum;
   logic [PW-1:0]    wptr, rptr;
   logic [CW-1:0]    count;
   logic [IDW-1:0]   tag_mem [MAX_OUT];
   logic [IDW-1:0]   tag_head;

   function automatic logic [NREQ-1:0] id_onehot(input logic [IDW-1:0] id);
      id_onehot     = '0;
      id_onehot[id] = 1'b1;
   endfunction

   // Highest k iterates first so the lowest rotated index wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      sum       = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + k[IDW:0];
         if (sum >= NREQ_W) sum = sum - NREQ_W;
         if (req_valid[sum[IDW-1:0]]) begin
            grant     = sum[IDW-1:0];
            any_valid = 1'b1;
         end
      end
   end

   assign grant_ok  = any_valid && (count < MAX_CNT);
   assign handshake = |(req_valid & req_ready);
   assign push      = (state == ISSUE) && core_in_ready;
   assign pop       = core_out_valid && (count != '0);
   assign tag_head  = tag_mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (handshake)     state_nxt = ISSUE;
         ISSUE:   if (core_in_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready     = '0;
      core_in_valid = 1'b0;
      if ((state == IDLE) && grant_ok && !rst) req_ready = id_onehot(grant);
      if (state == ISSUE) core_in_valid = 1'b1;
      busy = (state == ISSUE) || (count != '0);
   end

   // Operand hold stage: captured on grant, stable until the core accepts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_a  <= '0;
         core_b  <= '0;
         hold_id <= '0;
         rr_ptr  <= '0;
      end else begin
         if (handshake) begin
            core_a  <= req_a[grant*AW +: AW];
            core_b  <= req_b[grant*BW +: BW];
            hold_id <= grant;
         end
         if (push) rr_ptr <= (hold_id == LAST_ID) ? '0 : hold_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wptr] <= hold_id;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Response stage: one cycle after the core strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_c      <= '0;
         rsp_valid  <= '0;
         err_orphan <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (pop) begin
            rsp_c     <= core_c;
            rsp_valid <= id_onehot(tag_head);
         end
         if (core_out_valid && (count == '0)) err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_systolic_arbiter.sv
// Bench for systolic_arbiter: directed scenarios plus random traffic against a
// transaction-level model (rotating priority pointer and an owner-tag queue).
module tb_systolic_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 16;
   localparam int BW   = 16;
   localparam int CWD  = 36;
   localparam int MAXO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NREQ-1:0]  req_valid, req_ready, rsp_valid;
   logic [NREQ*AW-1:0] req_a;
   logic [NREQ*BW-1:0] req_b;
   logic [AW-1:0]    core_a;
   logic [BW-1:0]    core_b;
   logic             core_in_valid, core_in_ready, core_out_valid, busy, err_orphan;
   logic [CWD-1:0]   core_c, rsp_c;

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;
   int m_q[$];
   logic [CWD-1:0] m_last_c = '0;

   systolic_arbiter #(.NREQ(4), .ROWS(2), .COLS(2), .WIDTH(4), .ACC_WIDTH(9), .MAX_OUT(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .core_a(core_a), .core_b(core_b),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
      .core_c(core_c), .core_out_valid(core_out_valid), .rsp_c(rsp_c),
      .rsp_valid(rsp_valid), .busy(busy), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   function automatic int exp_grant(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++)
         if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int i);
      if (i < 0) return '0;
      return NREQ'(1 << i);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_ops;
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 4'b1111;
      randomize_ops();
      core_in_ready = 1'b0;
      core_out_valid = 1'b0;
      core_c = CWD'({$urandom, $urandom});
      tick(); tick(); #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
      total++; if ({core_in_valid, busy, err_orphan, rsp_valid} !== 7'b0) begin bad++;
         $display("FAIL rst_ctrl: got civ=%b busy=%b err=%b rsp_valid=%b want all 0", core_in_valid, busy, err_orphan, rsp_valid); end
      total++; if ({core_a, core_b, rsp_c} !== '0) begin bad++;
         $display("FAIL rst_data: got a=%h b=%h c=%h want 0", core_a, core_b, rsp_c); end
      rst = 1'b0;
      m_ptr = 0;
      m_q.delete();
      #1;
      total++; if (req_ready !== oh(exp_grant(req_valid))) begin bad++;
         $display("FAIL rst_first_grant: got %b want %b", req_ready, oh(exp_grant(req_valid))); end
      req_valid = '0;
   endtask

   task automatic test_drain;
      int t;
      while (m_q.size() > 0) begin
         core_out_valid = 1'b1;
         core_c = CWD'({$urandom, $urandom});
         m_last_c = core_c;
         t = m_q.pop_front();
         tick();
         core_out_valid = 1'b0;
         total++; if (rsp_valid !== oh(t) || rsp_c !== m_last_c) begin bad++;
            $display("FAIL drain_rsp: got v=%b c=%h want v=%b c=%h", rsp_valid, rsp_c, oh(t), m_last_c); end
      end
      tick();
      total++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL drain_idle: got v=%b busy=%b want 0 0", rsp_valid, busy); end
   endtask

   task automatic test_round_robin;
      int g, t;
      logic [CWD-1:0] c;
      randomize_ops();
      req_valid = 4'b1111;
      core_in_ready = 1'b1;
      core_out_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         g = exp_grant(req_valid);
         total++; if (req_ready !== oh(g) || core_in_valid !== 1'b0) begin bad++;
            $display("FAIL rr_grant%0d: got rdy=%b civ=%b want rdy=%b civ=0", j, req_ready, core_in_valid, oh(g)); end
         tick();
         if (j > 0) begin
            core_out_valid = 1'b1;
            core_c = CWD'({$urandom, $urandom});
            c = core_c;
            m_last_c = c;
            t = m_q.pop_front();
         end
         #1;
         total++; if (core_in_valid !== 1'b1 || req_ready !== 4'b0 || core_a !== req_a[g*AW +: AW] || core_b !== req_b[g*BW +: BW]) begin bad++;
            $display("FAIL rr_issue%0d: got civ=%b rdy=%b a=%h b=%h want civ=1 rdy=0 a=%h b=%h", j, core_in_valid, req_ready,
                     core_a, core_b, req_a[g*AW +: AW], req_b[g*BW +: BW]); end
         m_q.push_back(g);
         m_ptr = (g + 1) % NREQ;
         tick();
         core_out_valid = 1'b0;
         if (j > 0) begin
            total++; if (rsp_valid !== oh(t) || rsp_c !== c) begin bad++;
               $display("FAIL rr_rsp%0d: got v=%b c=%h want v=%b c=%h", j, rsp_valid, rsp_c, oh(t), c); end
         end
      end
      req_valid = '0;
      test_drain();
   endtask

   task automatic test_hold_stall;
      int g;
      logic [AW-1:0] ha;
      logic [BW-1:0] hb;
      randomize_ops();
      req_valid = 4'b0100;
      core_in_ready = 1'b0;
      #1;
      g = exp_grant(req_valid);
      total++; if (req_ready !== oh(g)) begin bad++; $display("FAIL hold_grant: got %b want %b", req_ready, oh(g)); end
      tick();
      ha = req_a[g*AW +: AW];
      hb = req_b[g*BW +: BW];
      randomize_ops();
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (core_in_valid !== 1'b1 || req_ready !== 4'b0 || core_a !== ha || core_b !== hb) begin bad++;
            $display("FAIL hold_stable%0d: got civ=%b rdy=%b a=%h b=%h want civ=1 rdy=0 a=%h b=%h", i, core_in_valid, req_ready,
                     core_a, core_b, ha, hb); end
         tick();
      end
      core_in_ready = 1'b1;
      tick();
      m_q.push_back(g);
      m_ptr = (g + 1) % NREQ;
      core_in_ready = 1'b0;
      #1;
      total++; if (core_in_valid !== 1'b0 || busy !== 1'b1 || req_ready !== oh(exp_grant(req_valid))) begin bad++;
         $display("FAIL hold_b2b: got civ=%b busy=%b rdy=%b want civ=0 busy=1 rdy=%b", core_in_valid, busy, req_ready,
                  oh(exp_grant(req_valid))); end
      req_valid = '0;
      test_drain();
   endtask

   task automatic test_full_and_push_pop;
      int g, t;
      logic [CWD-1:0] c;
      randomize_ops();
      req_valid = 4'b1111;
      core_in_ready = 1'b1;
      core_out_valid = 1'b0;
      for (int j = 0; j < MAXO; j++) begin
         #1;
         g = exp_grant(req_valid);
         total++; if (req_ready !== oh(g)) begin bad++; $display("FAIL full_fill%0d: got %b want %b", j, req_ready, oh(g)); end
         tick();
         m_q.push_back(g);
         m_ptr = (g + 1) % NREQ;
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (req_ready !== 4'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL full_block%0d: got rdy=%b busy=%b want 0000 1", i, req_ready, busy); end
         tick();
      end
      core_out_valid = 1'b1;
      core_c = CWD'({$urandom, $urandom});
      c = core_c;
      t = m_q.pop_front();
      #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL full_pop_cycle: got %b want 0000", req_ready); end
      tick();
      core_out_valid = 1'b0;
      #1;
      g = exp_grant(req_valid);
      total++; if (rsp_valid !== oh(t) || rsp_c !== c || req_ready !== oh(g)) begin bad++;
         $display("FAIL full_unblock: got v=%b c=%h rdy=%b want v=%b c=%h rdy=%b", rsp_valid, rsp_c, req_ready, oh(t), c, oh(g)); end
      tick();
      core_out_valid = 1'b1;
      core_c = CWD'({$urandom, $urandom});
      c = core_c;
      t = m_q.pop_front();
      m_q.push_back(g);
      m_ptr = (g + 1) % NREQ;
      tick();
      core_out_valid = 1'b0;
      #1;
      g = exp_grant(req_valid);
      total++; if (rsp_valid !== oh(t) || rsp_c !== c || req_ready !== oh(g)) begin bad++;
         $display("FAIL pushpop_kept: got v=%b c=%h rdy=%b want v=%b c=%h rdy=%b", rsp_valid, rsp_c, req_ready, oh(t), c, oh(g)); end
      tick();
      m_q.push_back(g);
      m_ptr = (g + 1) % NREQ;
      tick();
      #1;
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL pushpop_full_again: got %b want 0000", req_ready); end
      req_valid = '0;
      m_last_c = c;
      test_drain();
   endtask

   task automatic test_order;
      logic [CWD-1:0] x, y;
      int t1, t2;
      core_in_ready = 1'b1;
      req_valid = 4'b0010;
      #1;
      total++; if (req_ready !== oh(exp_grant(req_valid))) begin bad++; $display("FAIL order_grant1: got %b want %b", req_ready, oh(exp_grant(req_valid))); end
      tick();
      req_valid = '0;
      m_q.push_back(1); m_ptr = 2;
      tick();
      req_valid = 4'b1000;
      #1;
      total++; if (req_ready !== oh(exp_grant(req_valid))) begin bad++; $display("FAIL order_grant3: got %b want %b", req_ready, oh(exp_grant(req_valid))); end
      tick();
      req_valid = '0;
      m_q.push_back(3); m_ptr = 0;
      tick();
      x = CWD'({$urandom, $urandom});
      y = CWD'({$urandom, $urandom});
      t1 = m_q.pop_front();
      t2 = m_q.pop_front();
      core_out_valid = 1'b1;
      core_c = x;
      tick();
      core_c = y;
      #1;
      total++; if (rsp_valid !== oh(t1) || rsp_c !== x) begin bad++;
         $display("FAIL order_rsp_x: got v=%b c=%h want v=%b c=%h", rsp_valid, rsp_c, oh(t1), x); end
      tick();
      core_out_valid = 1'b0;
      #1;
      total++; if (rsp_valid !== oh(t2) || rsp_c !== y) begin bad++;
         $display("FAIL order_rsp_y: got v=%b c=%h want v=%b c=%h", rsp_valid, rsp_c, oh(t2), y); end
      tick();
      total++; if (rsp_valid !== 4'b0 || rsp_c !== y) begin bad++;
         $display("FAIL order_one_cycle: got v=%b c=%h want v=0000 c=%h", rsp_valid, rsp_c, y); end
      m_last_c = y;
   endtask

   task automatic test_random;
      bit m_hold = 0;
      int m_id = 0, g, pt = 0;
      bit prev_pop = 0;
      logic [AW-1:0] ha = '0;
      logic [BW-1:0] hb = '0;
      logic [CWD-1:0] pc = '0;
      logic [NREQ-1:0] er;
      for (int n = 0; n < 400; n++) begin
         req_valid = NREQ'($urandom);
         randomize_ops();
         core_in_ready = 1'($urandom);
         core_out_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
         core_c = CWD'({$urandom, $urandom});
         #1;
         g = exp_grant(req_valid);
         er = (!m_hold && m_q.size() < MAXO) ? oh(g) : '0;
         total++; if (req_ready !== er || core_in_valid !== m_hold) begin bad++;
            $display("FAIL rnd_ctrl%0d: got rdy=%b civ=%b want rdy=%b civ=%b", n, req_ready, core_in_valid, er, m_hold); end
         total++; if (busy !== (m_hold || m_q.size() > 0) || err_orphan !== 1'b0) begin bad++;
            $display("FAIL rnd_busy%0d: got busy=%b err=%b want busy=%b err=0", n, busy, err_orphan, (m_hold || m_q.size() > 0)); end
         if (m_hold) begin
            total++; if (core_a !== ha || core_b !== hb) begin bad++;
               $display("FAIL rnd_hold%0d: got a=%h b=%h want a=%h b=%h", n, core_a, core_b, ha, hb); end
         end
         total++; if (rsp_valid !== (prev_pop ? oh(pt) : 4'b0) || (prev_pop && rsp_c !== pc)) begin bad++;
            $display("FAIL rnd_rsp%0d: got v=%b c=%h want v=%b c=%h", n, rsp_valid, rsp_c, prev_pop ? oh(pt) : 4'b0, pc); end
         prev_pop = core_out_valid;
         if (core_out_valid) begin
            pt = m_q.pop_front();
            pc = core_c;
            m_last_c = pc;
         end
         if (m_hold && core_in_ready) begin
            m_q.push_back(m_id);
            m_ptr = (m_id + 1) % NREQ;
            m_hold = 0;
         end else if (!m_hold && er != '0) begin
            m_hold = 1;
            m_id = g;
            ha = req_a[g*AW +: AW];
            hb = req_b[g*BW +: BW];
         end
         tick();
      end
      req_valid = '0;
      core_out_valid = 1'b0;
      core_in_ready = 1'b1;
      tick();
      if (m_hold) begin
         m_q.push_back(m_id);
         m_ptr = (m_id + 1) % NREQ;
      end
      core_in_ready = 1'b0;
      test_drain();
   endtask

   task automatic test_orphan;
      core_out_valid = 1'b1;
      core_c = CWD'({$urandom, $urandom});
      tick();
      core_out_valid = 1'b0;
      #1;
      total++; if (err_orphan !== 1'b1 || rsp_valid !== 4'b0 || rsp_c !== m_last_c) begin bad++;
         $display("FAIL orphan_set: got err=%b v=%b c=%h want err=1 v=0000 c=%h", err_orphan, rsp_valid, rsp_c, m_last_c); end
      tick(); tick();
      total++; if (err_orphan !== 1'b1 || busy !== 1'b0) begin bad++;
         $display("FAIL orphan_sticky: got err=%b busy=%b want err=1 busy=0", err_orphan, busy); end
      rst = 1'b1;
      #1;
      total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_clear: got %b want 0", err_orphan); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_round_robin();
      test_hold_stall();
      test_full_and_push_pop();
      test_order();
      test_random();
      test_orphan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
